// File: rtl/pcp_pkg.sv
// Shared types and WAYS-range checks for the partitioned PLRU set.
package pcp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } pcp_state_e;

    localparam int MIN_WAYS = 2;
    localparam int MAX_WAYS = 16;

    function automatic bit ways_ok(input int w);
        return (w >= MIN_WAYS) && (w <= MAX_WAYS) && ((w & (w - 1)) == 0);
    endfunction

endpackage

// File: rtl/pcp_victim_sel.sv
// Combinational victim choice within one domain's ways: lowest invalid way,
// else lowest way with MRU clear, else lowest owned way.
module pcp_victim_sel #(
    parameter int WAYS = 8
) (
    input  logic [WAYS-1:0]         valid,
    input  logic [WAYS-1:0]         mru,
    input  logic [WAYS-1:0]         dom_mask,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic                    found
);

    localparam int IDX_W = $clog2(WAYS);

    logic             have_inv;
    logic             have_old;
    logic [IDX_W-1:0] inv_idx;
    logic [IDX_W-1:0] old_idx;
    logic [IDX_W-1:0] any_idx;

    // Descending scan so the last assignment wins, leaving the lowest index.
    always_comb begin
        have_inv = 1'b0;
        have_old = 1'b0;
        inv_idx  = '0;
        old_idx  = '0;
        any_idx  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (dom_mask[i]) begin
                any_idx = IDX_W'(i);
                if (!valid[i]) begin
                    have_inv = 1'b1;
                    inv_idx  = IDX_W'(i);
                end
                if (!mru[i]) begin
                    have_old = 1'b1;
                    old_idx  = IDX_W'(i);
                end
            end
        end
    end

    // The any_idx fallback covers a domain left with all-MRU ways after a
    // repartition removed its only MRU-clear way.
    assign found  = |dom_mask;
    assign victim = have_inv ? inv_idx : (have_old ? old_idx : any_idx);

endmodule

// File: rtl/partitioned_plru_set.sv
// One cache set whose ways are split between two security domains, with
// per-domain MRU-bit pseudo-LRU and a way-by-way flush on repartition.
module partitioned_plru_set
    import pcp_pkg::*;
#(
    parameter int              WAYS       = 8,
    parameter int              TAG_W      = 20,
    parameter logic [WAYS-1:0] PART_RESET = WAYS'(8'hF0)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_domain,
    input  logic [TAG_W-1:0]        req_tag,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic                    resp_fill,
    input  logic                    part_valid,
    input  logic [WAYS-1:0]         part_mask,
    output logic                    part_busy,
    output logic                    part_done,
    output logic [WAYS-1:0]         owner_mask,
    output pcp_state_e              dbg_state
);

    localparam int IDX_W = $clog2(WAYS);

    if (!ways_ok(WAYS)) begin : g_bad_ways
        $error("partitioned_plru_set: WAYS must be a power of two in 2..16");
    end

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // its response appears as a single-cycle resp_valid pulse on the next cycle.
    pcp_state_e       state_q, state_d;
    logic [WAYS-1:0]  valid_q, mru_q, owner_q, part_new_q, pending_q;
    logic [TAG_W-1:0] tag_q [WAYS];

    logic             resp_valid_q, resp_hit_q, resp_fill_q, part_done_q;
    logic [IDX_W-1:0] resp_way_q;

    logic             req_fire, part_fire;
    logic [WAYS-1:0]  dom_mask, hit_vec, acc_onehot, mru_set, mru_upd;
    logic             hit_any, found, do_access;
    logic [IDX_W-1:0] hit_idx, victim, acc_way;
    logic [IDX_W-1:0] flush_idx;
    logic [WAYS-1:0]  flush_onehot, pending_rest;
    logic             flush_last;

    assign req_fire  = req_valid && (state_q == IDLE);
    assign part_fire = part_valid && (state_q == IDLE);
    assign dom_mask  = req_domain ? owner_q : ~owner_q;

    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            hit_vec[i] = valid_q[i] && dom_mask[i] && (tag_q[i] == req_tag);
            if (hit_vec[i]) hit_idx = IDX_W'(i);
        end
    end

    assign hit_any = |hit_vec;

    pcp_victim_sel #(.WAYS(WAYS)) u_victim_sel (
        .valid    (valid_q),
        .mru      (mru_q),
        .dom_mask (dom_mask),
        .victim   (victim),
        .found    (found)
    );

    assign do_access  = req_fire && (hit_any || found);
    assign acc_way    = hit_any ? hit_idx : victim;
    assign acc_onehot = WAYS'(1) << acc_way;
    assign mru_set    = mru_q | acc_onehot;
    // Once every way of the domain is MRU, restart the epoch from the accessed way.
    assign mru_upd    = ((mru_set & dom_mask) == dom_mask) ?
                        ((mru_q & ~dom_mask) | acc_onehot) : mru_set;

    always_comb begin
        flush_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (pending_q[i]) flush_idx = IDX_W'(i);
        end
    end

    assign flush_onehot = pending_q & (WAYS'(1) << flush_idx);
    assign pending_rest = pending_q & ~flush_onehot;
    assign flush_last   = (pending_rest == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (part_fire) state_d = FLUSH;
            FLUSH:   if (flush_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= '0;
            mru_q        <= '0;
            owner_q      <= PART_RESET;
            part_new_q   <= '0;
            pending_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_fill_q  <= 1'b0;
            resp_way_q   <= '0;
            part_done_q  <= 1'b0;
            for (int i = 0; i < WAYS; i++) tag_q[i] <= '0;
        end else begin
            resp_valid_q <= req_fire;
            resp_hit_q   <= req_fire && hit_any;
            resp_fill_q  <= req_fire && !hit_any && found;
            resp_way_q   <= do_access ? acc_way : '0;
            part_done_q  <= 1'b0;
            if (do_access) begin
                valid_q[acc_way] <= 1'b1;
                tag_q[acc_way]   <= req_tag;
                mru_q            <= mru_upd;
            end
            if (part_fire) begin
                part_new_q <= part_mask;
                pending_q  <= owner_q ^ part_mask;
            end
            if (state_q == FLUSH) begin
                if (pending_q != '0) begin
                    valid_q[flush_idx] <= 1'b0;
                    mru_q[flush_idx]   <= 1'b0;
                end
                pending_q <= pending_rest;
                if (flush_last) begin
                    owner_q     <= part_new_q;
                    part_done_q <= 1'b1;
                end
            end
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign part_busy  = (state_q == FLUSH);
    assign part_done  = part_done_q;
    assign owner_mask = owner_q;
    assign resp_valid = resp_valid_q;
    assign resp_hit   = resp_hit_q;
    assign resp_way   = resp_way_q;
    assign resp_fill  = resp_fill_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_partitioned_plru_set.sv
// Bench for partitioned_plru_set (WAYS=4): directed scenarios plus random
// traffic checked against a list-based model of the replacement rules.
module tb_partitioned_plru_set;
  import pcp_pkg::*;

  localparam logic [3:0] PR = 4'b1100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_domain = 1'b0;
  logic [7:0] req_tag = '0;
  logic       resp_valid, resp_hit, resp_fill;
  logic [1:0] resp_way;
  logic       part_valid = 1'b0;
  logic [3:0] part_mask = '0;
  logic       part_busy, part_done;
  logic [3:0] owner_mask;
  pcp_state_e dbg_state;

  int checks = 0;
  int errors = 0;

  partitioned_plru_set #(.WAYS(4), .TAG_W(8), .PART_RESET(PR)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_domain(req_domain), .req_tag(req_tag), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .resp_way(resp_way), .resp_fill(resp_fill),
    .part_valid(part_valid), .part_mask(part_mask), .part_busy(part_busy),
    .part_done(part_done), .owner_mask(owner_mask), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: ways of a domain are listed in index order.
  bit         m_valid [4];
  bit         m_mru [4];
  logic [7:0] m_tag [4];
  logic [3:0] m_owner;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0;
      m_mru[i] = 0;
      m_tag[i] = '0;
    end
    m_owner = PR;
  endfunction

  function automatic void model_lookup(input bit dom, input logic [7:0] tag,
                                       output bit e_hit, output logic [1:0] e_way,
                                       output bit e_fill);
    int list[$];
    int w;
    bit all_mru;
    e_hit = 0;
    e_way = '0;
    e_fill = 0;
    w = -1;
    for (int i = 0; i < 4; i++) if (m_owner[i] == dom) list.push_back(i);
    if (list.size() == 0) return;
    foreach (list[k]) if (w < 0 && m_valid[list[k]] && m_tag[list[k]] == tag) w = list[k];
    if (w >= 0) begin
      e_hit = 1;
    end else begin
      e_fill = 1;
      foreach (list[k]) if (w < 0 && !m_valid[list[k]]) w = list[k];
      foreach (list[k]) if (w < 0 && !m_mru[list[k]]) w = list[k];
      if (w < 0) w = list[0];
      m_valid[w] = 1;
      m_tag[w] = tag;
    end
    e_way = 2'(w);
    m_mru[w] = 1;
    all_mru = 1;
    foreach (list[k]) if (!m_mru[list[k]]) all_mru = 0;
    if (all_mru) foreach (list[k]) if (list[k] != w) m_mru[list[k]] = 0;
  endfunction

  // Applies a repartition; returns the number of FLUSH cycles it should take.
  function automatic int model_part(input logic [3:0] nm);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (m_owner[i] != nm[i]) begin
        m_valid[i] = 0;
        m_mru[i] = 0;
        n++;
      end
    end
    m_owner = nm;
    return (n == 0) ? 1 : n;
  endfunction

  task automatic drive_req(input bit dom, input logic [7:0] tag, input bit with_part,
                           input logic [3:0] pm, output logic [4:0] o_resp);
    @(negedge clk);
    req_valid = 1'b1;
    req_domain = dom;
    req_tag = tag;
    part_valid = with_part;
    part_mask = pm;
    @(negedge clk);
    req_valid = 1'b0;
    part_valid = 1'b0;
    o_resp = {resp_valid, resp_hit, resp_way, resp_fill};
  endtask

  task automatic start_part(input logic [3:0] pm);
    @(negedge clk);
    part_valid = 1'b1;
    part_mask = pm;
    @(negedge clk);
    part_valid = 1'b0;
  endtask

  task automatic wait_part(output int busy, output bit done, output bit rdy_bad,
                           output logic [3:0] own);
    busy = 0;
    done = 0;
    rdy_bad = 0;
    own = 'x;
    for (int c = 0; c < 20; c++) begin
      if (part_done) begin
        done = 1;
        own = owner_mask;
        break;
      end
      if (part_busy) busy++;
      if (part_busy && req_ready) rdy_bad = 1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (owner_mask !== PR) begin
      errors++;
      $display("FAIL reset_owner got %b exp %b", owner_mask, PR);
    end
    checks++;
    if ({resp_valid, resp_hit, resp_way, resp_fill} !== 5'b0) begin
      errors++;
      $display("FAIL reset_resp got %b exp 00000", {resp_valid, resp_hit, resp_way, resp_fill});
    end
    checks++;
    if ({req_ready, part_busy, part_done} !== 3'b100 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_ctrl got ready/busy/done=%b state=%0d exp 100 state=0",
               {req_ready, part_busy, part_done}, dbg_state);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_resp(input string name, input logic [4:0] got, input logic [4:0] exp);
    // thin wrapper avoided on purpose; unused
  endtask

  task automatic test_fill_hit();
    logic [4:0] r;
    drive_req(0, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_0_00_1) begin errors++; $display("FAIL fill_t1 got %b exp 10001", r); end
    drive_req(0, 8'd2, 0, '0, r);
    checks++;
    if (r !== 5'b1_0_01_1) begin errors++; $display("FAIL fill_t2 got %b exp 10011", r); end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_hit, resp_way, resp_fill} !== 5'b0) begin
      errors++;
      $display("FAIL resp_pulse got %b exp 00000", {resp_valid, resp_hit, resp_way, resp_fill});
    end
    drive_req(0, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_1_00_0) begin errors++; $display("FAIL hit_t1 got %b exp 11000", r); end
    drive_req(1, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_0_10_1) begin errors++; $display("FAIL d1_fill_t1 got %b exp 10101", r); end
  endtask

  task automatic test_plru();
    logic [4:0] r;
    drive_req(0, 8'd2, 0, '0, r);
    checks++;
    if (r !== 5'b1_1_01_0) begin errors++; $display("FAIL plru_hit_t2 got %b exp 11010", r); end
    drive_req(0, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_1_00_0) begin errors++; $display("FAIL plru_hit_t1 got %b exp 11000", r); end
    drive_req(0, 8'd3, 0, '0, r);
    checks++;
    if (r !== 5'b1_0_01_1) begin errors++; $display("FAIL plru_victim got %b exp 10011", r); end
    drive_req(1, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_1_10_0) begin errors++; $display("FAIL d1_untouched got %b exp 11100", r); end
  endtask

  task automatic test_repartition();
    logic [4:0] r;
    logic [3:0] own;
    int busy;
    bit done, rdy_bad;
    start_part(4'b1110);
    wait_part(busy, done, rdy_bad, own);
    checks++;
    if (!done || busy != 1 || rdy_bad || own !== 4'b1110) begin
      errors++;
      $display("FAIL part_1110 got done=%0d busy=%0d rdy_bad=%0d owner=%b exp 1/1/0/1110",
               done, busy, rdy_bad, own);
    end
    @(negedge clk);
    checks++;
    if ({part_done, part_busy} !== 2'b00) begin
      errors++;
      $display("FAIL part_done_pulse got done/busy=%b exp 00", {part_done, part_busy});
    end
    drive_req(0, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_1_00_0) begin errors++; $display("FAIL keep_way0 got %b exp 11000", r); end
    drive_req(1, 8'd3, 0, '0, r);
    checks++;
    if (r !== 5'b1_0_01_1) begin errors++; $display("FAIL way1_flushed got %b exp 10011", r); end
  endtask

  task automatic test_same_cycle_empty_domain();
    logic [4:0] r;
    logic [3:0] own;
    int busy;
    bit done, rdy_bad;
    drive_req(0, 8'd1, 1, 4'b1111, r);
    checks++;
    if (r !== 5'b1_1_00_0) begin errors++; $display("FAIL same_cycle_old_mask got %b exp 11000", r); end
    wait_part(busy, done, rdy_bad, own);
    checks++;
    if (!done || busy != 1 || rdy_bad || own !== 4'b1111) begin
      errors++;
      $display("FAIL part_1111 got done=%0d busy=%0d rdy_bad=%0d owner=%b exp 1/1/0/1111",
               done, busy, rdy_bad, own);
    end
    drive_req(0, 8'd1, 0, '0, r);
    checks++;
    if (r !== 5'b1_0_00_0) begin errors++; $display("FAIL empty_domain got %b exp 10000", r); end
  endtask

  task automatic test_reset_mid_flush();
    logic [4:0] r;
    logic [1:0] e_way;
    bit e_hit, e_fill, spurious;
    start_part(4'b0000);
    @(negedge clk);
    reset = 1'b1;
    #2;
    checks++;
    if (owner_mask !== PR || part_busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flush got owner=%b busy=%b ready=%b exp %b/0/1",
               owner_mask, part_busy, req_ready, PR);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    spurious = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (part_done || part_busy) spurious = 1;
    end
    checks++;
    if (spurious) begin errors++; $display("FAIL flush_discarded got activity=1 exp 0"); end
    drive_req(1, 8'd1, 0, '0, r);
    model_lookup(1, 8'd1, e_hit, e_way, e_fill);
    checks++;
    if (r !== 5'b1_0_10_1) begin errors++; $display("FAIL post_reset_d1 got %b exp 10101", r); end
    drive_req(0, 8'd1, 0, '0, r);
    model_lookup(0, 8'd1, e_hit, e_way, e_fill);
    checks++;
    if (r !== 5'b1_0_00_1) begin errors++; $display("FAIL post_reset_d0 got %b exp 10001", r); end
  endtask

  task automatic test_random();
    logic [4:0] r;
    logic [3:0] own, nm;
    logic [1:0] e_way;
    logic [7:0] tag;
    bit e_hit, e_fill, done, rdy_bad, dom, same;
    int busy, e_busy, kind;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      dom = 1'($urandom_range(0, 1));
      tag = 8'($urandom_range(1, 6));
      nm = 4'($urandom_range(0, 15));
      if (kind == 0) begin
        start_part(nm);
        e_busy = model_part(nm);
        wait_part(busy, done, rdy_bad, own);
        checks++;
        if (!done || busy != e_busy || rdy_bad || own !== nm) begin
          errors++;
          $display("FAIL rand_part[%0d] got done=%0d busy=%0d rdy_bad=%0d owner=%b exp 1/%0d/0/%b",
                   n, done, busy, rdy_bad, own, e_busy, nm);
        end
      end else begin
        same = (kind == 1);
        drive_req(dom, tag, same, nm, r);
        model_lookup(dom, tag, e_hit, e_way, e_fill);
        checks++;
        if (r !== {1'b1, e_hit, e_way, e_fill}) begin
          errors++;
          $display("FAIL rand_req[%0d] dom=%0d tag=%0d got %b exp %b",
                   n, dom, tag, r, {1'b1, e_hit, e_way, e_fill});
        end
        if (same) begin
          e_busy = model_part(nm);
          wait_part(busy, done, rdy_bad, own);
          checks++;
          if (!done || busy != e_busy || own !== nm) begin
            errors++;
            $display("FAIL rand_same[%0d] got done=%0d busy=%0d owner=%b exp 1/%0d/%b",
                     n, done, busy, own, e_busy, nm);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_hit();
    test_plru();
    test_repartition();
    test_same_cycle_empty_domain();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/partitioned_plru_set.md
PARTITIONED_PLRU_SET -- requirements
Module: partitioned_plru_set

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning number of ways; a power of two, 2..16.
REQ-002 SHALL have parameter TAG_W, default 20, meaning stored tag width in bits.
REQ-003 SHALL have parameter PART_RESET, default 8'hF0, WAYS bits wide, meaning ownership mask loaded at reset; bit i=1 means way i belongs to domain 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, lookup request.
REQ-007 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-008 SHALL have port req_domain, input, 1, requesting security domain (0 or 1).
REQ-009 SHALL have port req_tag, input, TAG_W, lookup tag.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle response pulse.
REQ-011 SHALL have port resp_hit, output, 1, hit indication.
REQ-012 SHALL have port resp_way, output, $clog2(WAYS), way hit or filled.
REQ-013 SHALL have port resp_fill, output, 1, miss caused a fill.
REQ-014 SHALL have port part_valid, input, 1, repartition request.
REQ-015 SHALL have port part_mask, input, WAYS, new ownership mask.
REQ-016 SHALL have port part_busy, output, 1, repartition in progress.
REQ-017 SHALL have port part_done, output, 1, one-cycle pulse when the new mask takes effect.
REQ-018 SHALL have port owner_mask, output, WAYS, current ownership mask.

Function
REQ-019 Per way state: valid bit, TAG_W tag, MRU bit.
REQ-020 FSM states IDLE and FLUSH; req_ready = (state==IDLE).
REQ-021 Accepted request: responses registered, resp_valid exactly 1 cycle later; resp_hit/resp_way/resp_fill held 0 whenever resp_valid=0.
REQ-022 Hit: only valid ways owned by req_domain with matching tag; ways of the other domain never hit, never change state.
REQ-023 Hit: set MRU of hit way; if all ways owned by the domain then have MRU=1, clear MRU of every other way of that domain.
REQ-024 Miss, victim = lowest-index invalid way of the domain, else lowest-index way of the domain with MRU=0; victim gets valid=1, tag=req_tag, MRU updated as REQ-023; resp_fill=1, resp_way=victim.
REQ-025 Miss with domain owning zero ways: resp_hit=0, resp_fill=0, resp_way=0, no state change.
REQ-026 Multiple tag matches (impossible by construction) resolved to lowest index.
REQ-027 part_valid in IDLE: accept, latch part_mask, go FLUSH next cycle; part_valid outside IDLE ignored.
REQ-028 req_valid and part_valid in the same IDLE cycle: request served against the old mask, then FLUSH.
REQ-029 FLUSH: each way whose owner bit differs between old and new mask invalidated (valid=0, MRU=0), one way per cycle, ascending index; part_busy=1 throughout.
REQ-030 After last changed way (or one cycle if none change): owner_mask<=new mask, part_done pulses 1 cycle, return IDLE.
REQ-031 Unchanged-owner ways keep valid, tag and MRU across repartition.

Reset
REQ-032 Asynchronous reset: all valid=0, MRU=0, tags=0, owner_mask=PART_RESET, state=IDLE, resp_*=0, part_busy=0, part_done=0.
REQ-033 Reset during FLUSH aborts; latched mask discarded.

Structure
REQ-034 Package pcp_pkg SHALL hold the state enum (IDLE, FLUSH) and WAYS-range constants/checks.
REQ-035 Sub-module pcp_victim_sel SHALL compute victim index and found flag combinationally from valid, MRU and domain-way mask.

Verification
REQ-036 WAYS=4, PART_RESET=4'b1100: domain 0 misses tags 1,2 -> fills way 0 then 1, resp_fill=1 each.
REQ-037 Then domain 0 hits tag 1 -> resp_hit=1, resp_way=0; domain 1 lookup tag 1 -> miss, fill way 2.
REQ-038 Domain 0 tags 1,2 hit alternately, then tag 3 -> victim is the way not most recently used; domain 1 state unchanged.
REQ-039 part_mask=4'b1110 -> only way 1 invalidated, 1 FLUSH cycle, part_done pulse, req_ready low during FLUSH; tag 1 still hits way 0.
REQ-040 part_mask=4'b1111 -> domain 0 lookup: resp_hit=0, resp_fill=0, resp_way=0.
REQ-041 reset asserted mid-FLUSH -> owner_mask=PART_RESET, all ways invalid, IDLE.
